// File: rtl/mc_ctrl_pkg.sv
// Shared opcodes, state encodings and mux/ALU codes for the multicycle control unit.
package mc_ctrl_pkg;

    // Instruction register opcode field [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNEQ  = 6'b000101;
    localparam logic [5:0] OP_JMP   = 6'b000110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StWbAlu   = 4'd4,
        StBranch  = 4'd5,
        StJump    = 4'd6,
        StMemAddr = 4'd7,
        StMemRd   = 4'd8,
        StWbMem   = 4'd9,
        StMemWr   = 4'd10,
        StFault   = 4'd11
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that own the memory port and wait on mem_ready
    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_ctrl_unit_mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle on which the wait budget runs out.
module mem_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_ready,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Wait counter: cleared on entry to a wait state, frozen when not enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !i_ready) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Last permitted wait cycle with no ready; ready on this cycle still completes
    assign o_expired = i_enable && !i_ready && (r_count == LAST_WAIT);

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS control FSM sharing one memory port, with ready timeout, hold and fault.
module mc_ctrl_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       hold,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       write_to_regfile,
    output logic       reg_destination,
    output logic       alu_source_imm,
    output logic [1:0] alu_op,
    output logic       mem_to_reg,
    output logic       instr_retired,
    output logic       fault,
    output logic [3:0] state_o
);

    state_e r_state;
    state_e w_state_d;
    logic   r_rtype, r_sub, r_isload, r_isbeq;
    logic   w_timer_en, w_timer_clear, w_expired;

    assign w_timer_en    = is_wait_state(r_state) && !hold;
    assign w_timer_clear = (w_state_d != r_state) && is_wait_state(w_state_d);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .i_ready  (mem_ready),
        .o_expired(w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Instruction class flags captured while the opcode is decoded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rtype  <= 1'b0;
            r_sub    <= 1'b0;
            r_isload <= 1'b0;
            r_isbeq  <= 1'b0;
        end else if ((r_state == StDecode) && !hold) begin
            r_rtype  <= (opcode == OP_RTYPE);
            r_sub    <= (opcode == OP_SUBI);
            r_isload <= (opcode == OP_LW);
            r_isbeq  <= (opcode == OP_BEQ);
        end
    end

    // Next-state and control outputs, then hold and reset overrides
    always_comb begin
        w_state_d        = r_state;
        pc_write         = 1'b0;
        pc_source        = PCSRC_PC4;
        ir_write         = 1'b0;
        i_or_d           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        write_to_regfile = 1'b0;
        reg_destination  = 1'b0;
        alu_source_imm   = 1'b0;
        alu_op           = ALU_ADD;
        mem_to_reg       = 1'b0;
        instr_retired    = 1'b0;
        fault            = 1'b0;

        unique case (r_state)
            StFetch: begin
                mem_read = 1'b1;
                if (w_expired) begin
                    w_state_d = StFault;
                end else if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    w_state_d = StDecode;
                end
            end
            StDecode: begin
                unique case (opcode)
                    OP_RTYPE:        w_state_d = StExecR;
                    OP_ADDI, OP_SUBI: w_state_d = StExecI;
                    OP_BEQ, OP_BNEQ: w_state_d = StBranch;
                    OP_JMP:          w_state_d = StJump;
                    OP_LW, OP_SW:    w_state_d = StMemAddr;
                    default: begin
                        instr_retired = 1'b1;
                        w_state_d     = StFetch;
                    end
                endcase
            end
            StExecR: begin
                alu_op    = ALU_FUNCT;
                w_state_d = StWbAlu;
            end
            StExecI: begin
                alu_source_imm = 1'b1;
                alu_op         = r_sub ? ALU_SUB : ALU_ADD;
                w_state_d      = StWbAlu;
            end
            StWbAlu: begin
                write_to_regfile = 1'b1;
                reg_destination  = r_rtype;
                instr_retired    = 1'b1;
                w_state_d        = StFetch;
            end
            StBranch: begin
                alu_op        = ALU_SUB;
                pc_source     = PCSRC_BRANCH;
                pc_write      = (r_isbeq & zero) | (!r_isbeq & !zero);
                instr_retired = 1'b1;
                w_state_d     = StFetch;
            end
            StJump: begin
                pc_source     = PCSRC_JUMP;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                w_state_d     = StFetch;
            end
            StMemAddr: begin
                alu_source_imm = 1'b1;
                alu_op         = ALU_ADD;
                w_state_d      = r_isload ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (w_expired) begin
                    w_state_d = StFault;
                end else if (mem_ready) begin
                    w_state_d = StWbMem;
                end
            end
            StWbMem: begin
                write_to_regfile = 1'b1;
                mem_to_reg       = 1'b1;
                instr_retired    = 1'b1;
                w_state_d        = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (w_expired) begin
                    w_state_d = StFault;
                end else if (mem_ready) begin
                    instr_retired = 1'b1;
                    w_state_d     = StFetch;
                end
            end
            StFault: begin
                fault = 1'b1;
            end
            default: begin
                w_state_d = StFetch;
            end
        endcase

        // Stall: freeze state, suppress every architectural side effect
        if (hold && (r_state != StFault)) begin
            w_state_d        = r_state;
            pc_write         = 1'b0;
            ir_write         = 1'b0;
            write_to_regfile = 1'b0;
            mem_write        = 1'b0;
            instr_retired    = 1'b0;
        end

        if (rst) begin
            pc_write         = 1'b0;
            pc_source        = PCSRC_PC4;
            ir_write         = 1'b0;
            i_or_d           = 1'b0;
            mem_read         = 1'b0;
            mem_write        = 1'b0;
            write_to_regfile = 1'b0;
            reg_destination  = 1'b0;
            alu_source_imm   = 1'b0;
            alu_op           = ALU_ADD;
            mem_to_reg       = 1'b0;
            instr_retired    = 1'b0;
            fault            = 1'b0;
        end
    end

    assign state_o = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: per-cycle state and control vectors checked against hand tables.
module tb_mc_ctrl_unit;
    import mc_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       hold;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       write_to_regfile;
    logic       reg_destination;
    logic       alu_source_imm;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       instr_retired;
    logic       fault;
    logic [3:0] state_o;

    mc_ctrl_unit #(
        .MEM_TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .opcode          (opcode),
        .zero            (zero),
        .mem_ready       (mem_ready),
        .hold            (hold),
        .pc_write        (pc_write),
        .pc_source       (pc_source),
        .ir_write        (ir_write),
        .i_or_d          (i_or_d),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .write_to_regfile(write_to_regfile),
        .reg_destination (reg_destination),
        .alu_source_imm  (alu_source_imm),
        .alu_op          (alu_op),
        .mem_to_reg      (mem_to_reg),
        .instr_retired   (instr_retired),
        .fault           (fault),
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write, write_to_regfile,
    //  reg_destination, alu_source_imm, alu_op, mem_to_reg, instr_retired, fault}
    logic [14:0] w_ctl;
    assign w_ctl = {pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write, write_to_regfile,
                    reg_destination, alu_source_imm, alu_op, mem_to_reg, instr_retired, fault};

    localparam logic [14:0] E_ZERO       = 15'b0_00_0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_FETCH_WAIT = 15'b0_00_0_0_1_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_FETCH_RDY  = 15'b1_00_1_0_1_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_NOP        = 15'b0_00_0_0_0_0_0_0_0_00_0_1_0;
    localparam logic [14:0] E_EXEC_R     = 15'b0_00_0_0_0_0_0_0_0_10_0_0_0;
    localparam logic [14:0] E_EXEC_ADD   = 15'b0_00_0_0_0_0_0_0_1_00_0_0_0;
    localparam logic [14:0] E_EXEC_SUB   = 15'b0_00_0_0_0_0_0_0_1_01_0_0_0;
    localparam logic [14:0] E_WB_I       = 15'b0_00_0_0_0_0_1_0_0_00_0_1_0;
    localparam logic [14:0] E_WB_R       = 15'b0_00_0_0_0_0_1_1_0_00_0_1_0;
    localparam logic [14:0] E_WB_R_HOLD  = 15'b0_00_0_0_0_0_0_1_0_00_0_0_0;
    localparam logic [14:0] E_BR_TAKEN   = 15'b1_01_0_0_0_0_0_0_0_01_0_1_0;
    localparam logic [14:0] E_BR_NOT     = 15'b0_01_0_0_0_0_0_0_0_01_0_1_0;
    localparam logic [14:0] E_JUMP       = 15'b1_10_0_0_0_0_0_0_0_00_0_1_0;
    localparam logic [14:0] E_MEM_RD     = 15'b0_00_0_1_1_0_0_0_0_00_0_0_0;
    localparam logic [14:0] E_WB_MEM     = 15'b0_00_0_0_0_0_1_0_0_00_1_1_0;
    localparam logic [14:0] E_MEM_WR     = 15'b0_00_0_1_0_1_0_0_0_00_0_0_0;
    localparam logic [14:0] E_FAULT      = 15'b0_00_0_0_0_0_0_0_0_00_0_0_1;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct packed {
        logic        rst;
        logic        hold;
        logic        rdy;
        logic        zero;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [14:0] ctl;
    } row_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic row_t mk(input logic r, input logic h, input logic rd, input logic z,
                                input logic [5:0] op, input state_e st, input logic [14:0] ctl);
        row_t x;
        x.rst  = r;
        x.hold = h;
        x.rdy  = rd;
        x.zero = z;
        x.op   = op;
        x.st   = st;
        x.ctl  = ctl;
        return x;
    endfunction

    // Apply one cycle of inputs after the falling edge, then let the Mealy outputs settle
    task automatic drive(input row_t x);
        @(negedge clk);
        rst       = x.rst;
        hold      = x.hold;
        mem_ready = x.rdy;
        zero      = x.zero;
        opcode    = x.op;
        #1;
    endtask

    task automatic test_reset();
        row_t v[$];
        v.push_back(mk(H, H, H, L, OP_ADDI, StFetch, E_ZERO));
        v.push_back(mk(H, L, L, L, OP_ADDI, StFetch, E_ZERO));
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            n_checks++;
            if ({state_o, w_ctl} !== {v[i].st, v[i].ctl}) begin
                n_fail++;
                $display("FAIL reset[%0d]: state_o=%0d ctl=%b, expected state=%0d ctl=%b",
                         i, state_o, w_ctl, v[i].st, v[i].ctl);
            end
        end
    endtask

    task automatic test_alu_imm();
        row_t v[$];
        v.push_back(mk(L, L, H, L, OP_ADDI, StFetch,  E_FETCH_RDY));
        v.push_back(mk(L, L, H, L, OP_ADDI, StDecode, E_ZERO));
        v.push_back(mk(L, L, H, L, OP_ADDI, StExecI,  E_EXEC_ADD));
        v.push_back(mk(L, L, H, L, OP_ADDI, StWbAlu,  E_WB_I));
        v.push_back(mk(L, L, H, L, OP_SUBI, StFetch,  E_FETCH_RDY));
        v.push_back(mk(L, L, H, L, OP_SUBI, StDecode, E_ZERO));
        v.push_back(mk(L, L, H, L, OP_SUBI, StExecI,  E_EXEC_SUB));
        v.push_back(mk(L, L, H, L, OP_SUBI, StWbAlu,  E_WB_I));
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            n_checks++;
            if ({state_o, w_ctl} !== {v[i].st, v[i].ctl}) begin
                n_fail++;
                $display("FAIL alu_imm[%0d]: state_o=%0d ctl=%b, expected state=%0d ctl=%b",
                         i, state_o, w_ctl, v[i].st, v[i].ctl);
            end
        end
    endtask

    task automatic test_branch_jump();
        row_t v[$];
        v.push_back(mk(L, L, H, H, OP_BEQ,  StFetch,  E_FETCH_RDY));
        v.push_back(mk(L, L, H, H, OP_BEQ,  StDecode, E_ZERO));
        v.push_back(mk(L, L, H, H, OP_BEQ,  StBranch, E_BR_TAKEN));
        v.push_back(mk(L, L, H, L, OP_BEQ,  StFetch,  E_FETCH_RDY));
        v.push_back(mk(L, L, H, L, OP_BEQ,  StDecode, E_ZERO));
        v.push_back(mk(L, L, H, L, OP_BEQ,  StBranch, E_BR_NOT));
        v.push_back(mk(L, L, H, L, OP_BNEQ, StFetch,  E_FETCH_RDY));
        v.push_back(mk(L, L, H, L, OP_BNEQ, StDecode, E_ZERO));
        v.push_back(mk(L, L, H, L, OP_BNEQ, StBranch, E_BR_TAKEN));
        v.push_back(mk(L, L, H, H, OP_BNEQ, StFetch,  E_FETCH_RDY));
        v.push_back(mk(L, L, H, H, OP_BNEQ, StDecode, E_ZERO));
        v.push_back(mk(L, L, H, H, OP_BNEQ, StBranch, E_BR_NOT));
        v.push_back(mk(L, L, H, L, OP_JMP,  StFetch,  E_FETCH_RDY));
        v.push_back(mk(L, L, H, L, OP_JMP,  StDecode, E_ZERO));
        v.push_back(mk(L, L, H, L, OP_JMP,  StJump,   E_JUMP));
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            n_checks++;
            if ({state_o, w_ctl} !== {v[i].st, v[i].ctl}) begin
                n_fail++;
                $display("FAIL branch_jump[%0d]: state_o=%0d ctl=%b, expected state=%0d ctl=%b",
                         i, state_o, w_ctl, v[i].st, v[i].ctl);
            end
        end
    endtask

    // Three wait cycles in each memory state; ready lands on the last permitted wait cycle
    task automatic test_lw_delayed();
        row_t v[$];
        for (int k = 0; k < 3; k++) v.push_back(mk(L, L, L, L, OP_LW, StFetch, E_FETCH_WAIT));
        v.push_back(mk(L, L, H, L, OP_LW, StFetch,   E_FETCH_RDY));
        v.push_back(mk(L, L, L, L, OP_LW, StDecode,  E_ZERO));
        v.push_back(mk(L, L, L, L, OP_LW, StMemAddr, E_EXEC_ADD));
        for (int k = 0; k < 3; k++) v.push_back(mk(L, L, L, L, OP_LW, StMemRd, E_MEM_RD));
        v.push_back(mk(L, L, H, L, OP_LW, StMemRd,   E_MEM_RD));
        v.push_back(mk(L, L, L, L, OP_LW, StWbMem,   E_WB_MEM));
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            n_checks++;
            if ({state_o, w_ctl} !== {v[i].st, v[i].ctl}) begin
                n_fail++;
                $display("FAIL lw_delayed[%0d]: state_o=%0d ctl=%b, expected state=%0d ctl=%b",
                         i, state_o, w_ctl, v[i].st, v[i].ctl);
            end
        end
    endtask

    task automatic test_timeout();
        row_t v[$];
        v.push_back(mk(L, L, H, L, OP_SW, StFetch,   E_FETCH_RDY));
        v.push_back(mk(L, L, L, L, OP_SW, StDecode,  E_ZERO));
        v.push_back(mk(L, L, L, L, OP_SW, StMemAddr, E_EXEC_ADD));
        for (int k = 0; k < 4; k++) v.push_back(mk(L, L, L, L, OP_SW, StMemWr, E_MEM_WR));
        v.push_back(mk(L, L, L, L, OP_SW, StFault,   E_FAULT));
        v.push_back(mk(L, H, H, L, OP_SW, StFault,   E_FAULT));
        v.push_back(mk(L, L, H, L, OP_SW, StFault,   E_FAULT));
        v.push_back(mk(H, L, L, L, OP_SW, StFetch,   E_ZERO));
        for (int k = 0; k < 4; k++) v.push_back(mk(L, L, L, L, OP_SW, StFetch, E_FETCH_WAIT));
        v.push_back(mk(L, L, L, L, OP_SW, StFault,   E_FAULT));
        v.push_back(mk(H, L, L, L, OP_SW, StFetch,   E_ZERO));
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            n_checks++;
            if ({state_o, w_ctl} !== {v[i].st, v[i].ctl}) begin
                n_fail++;
                $display("FAIL timeout[%0d]: state_o=%0d ctl=%b, expected state=%0d ctl=%b",
                         i, state_o, w_ctl, v[i].st, v[i].ctl);
            end
        end
    endtask

    // Hold in WB_ALU, then hold mid-FETCH wait: a frozen counter faults only after 4 live waits
    task automatic test_hold();
        row_t v[$];
        v.push_back(mk(L, L, H, L, OP_RTYPE, StFetch,  E_FETCH_RDY));
        v.push_back(mk(L, L, H, L, OP_RTYPE, StDecode, E_ZERO));
        v.push_back(mk(L, L, H, L, OP_RTYPE, StExecR,  E_EXEC_R));
        for (int k = 0; k < 5; k++) v.push_back(mk(L, H, H, L, OP_RTYPE, StWbAlu, E_WB_R_HOLD));
        v.push_back(mk(L, L, H, L, OP_RTYPE, StWbAlu,  E_WB_R));
        v.push_back(mk(L, L, L, L, OP_RTYPE, StFetch,  E_FETCH_WAIT));
        v.push_back(mk(L, L, L, L, OP_RTYPE, StFetch,  E_FETCH_WAIT));
        v.push_back(mk(L, H, H, L, OP_RTYPE, StFetch,  E_FETCH_WAIT));
        v.push_back(mk(L, H, L, L, OP_RTYPE, StFetch,  E_FETCH_WAIT));
        v.push_back(mk(L, H, L, L, OP_RTYPE, StFetch,  E_FETCH_WAIT));
        v.push_back(mk(L, L, L, L, OP_RTYPE, StFetch,  E_FETCH_WAIT));
        v.push_back(mk(L, L, L, L, OP_RTYPE, StFetch,  E_FETCH_WAIT));
        v.push_back(mk(L, L, L, L, OP_RTYPE, StFault,  E_FAULT));
        v.push_back(mk(H, H, L, L, OP_RTYPE, StFetch,  E_ZERO));
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            n_checks++;
            if ({state_o, w_ctl} !== {v[i].st, v[i].ctl}) begin
                n_fail++;
                $display("FAIL hold[%0d]: state_o=%0d ctl=%b, expected state=%0d ctl=%b",
                         i, state_o, w_ctl, v[i].st, v[i].ctl);
            end
        end
    endtask

    task automatic test_nop_and_abort();
        row_t v[$];
        v.push_back(mk(L, L, H, L, OP_BAD, StFetch,   E_FETCH_RDY));
        v.push_back(mk(L, L, H, L, OP_BAD, StDecode,  E_NOP));
        v.push_back(mk(L, L, H, L, OP_SW,  StFetch,   E_FETCH_RDY));
        v.push_back(mk(L, L, H, L, OP_SW,  StDecode,  E_ZERO));
        v.push_back(mk(L, L, L, L, OP_SW,  StMemAddr, E_EXEC_ADD));
        v.push_back(mk(L, L, L, L, OP_SW,  StMemWr,   E_MEM_WR));
        v.push_back(mk(H, L, H, L, OP_SW,  StFetch,   E_ZERO));
        v.push_back(mk(L, L, L, L, OP_SW,  StFetch,   E_FETCH_WAIT));
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            n_checks++;
            if ({state_o, w_ctl} !== {v[i].st, v[i].ctl}) begin
                n_fail++;
                $display("FAIL nop_abort[%0d]: state_o=%0d ctl=%b, expected state=%0d ctl=%b",
                         i, state_o, w_ctl, v[i].st, v[i].ctl);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = 6'b000000;
        test_reset();
        test_alu_imm();
        test_branch_jump();
        test_lw_delayed();
        test_timeout();
        test_hold();
        test_nop_and_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
